ray_result_collector: RTL and testbench

Parametrised successor to the single-core shade-output path and pixel counter. Accepts shaded-pixel results from NUM_CORES parallel ray cores, buffers each core in its own FIFO, and arbitrates round-robin onto one ready/valid stream toward the frame buffer. Keeps a total pixel count and per-core pixel counts, and raises a sticky frame-done flag when a programmed pixel total is reached.

---
 rtl/ray_result_collector_pkg.sv | 15 +
 rtl/ray_result_collector_if.sv | 30 +++
 rtl/ray_result_collector_fifo.sv | 49 ++++
 rtl/ray_result_collector.sv | 127 ++++++++++++
 tb/tb_ray_result_collector.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ray_result_collector_pkg.sv
// Shared types and limits for the ray result collector.
// Used by the core/framebuffer interface and the collector itself.
package ray_result_collector_pkg;

  localparam int RC_MAX_CORES = 16;
  localparam int RC_CNT_W     = 32;
  localparam int RC_DATA_W    = 64;

  typedef logic [RC_DATA_W-1:0] pixel_result_t;

  function automatic int rc_core_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ray_result_collector_if.sv
// Ray-core result inputs and framebuffer output stream.
// slave is the collector side, master the cores/framebuffer side.
interface ray_result_collector_if
  import ray_result_collector_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = RC_DATA_W
);

  localparam int CORE_W = rc_core_w(NUM_CORES);

  logic [NUM_CORES-1:0]        in_valid;
  logic [NUM_CORES*DATA_W-1:0] in_data;
  logic [NUM_CORES-1:0]        fifo_full;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_W-1:0]           out_data;
  logic [CORE_W-1:0]           out_core;

  modport slave (
    input  in_valid, in_data, out_ready,
    output fifo_full, out_valid, out_data, out_core
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  fifo_full, out_valid, out_data, out_core
  );

endinterface

// File: rtl/ray_result_collector_fifo.sv
// Per-core result buffer: synchronous FIFO with occupancy count.
// Writes to a full FIFO and reads from an empty one are ignored.
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  assign wr   = push && (count != CW'(DEPTH));
  assign rd   = pop && (count != '0);
  assign dout = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ray_result_collector.sv
// Multi-core shaded-pixel collector: per-core FIFOs, round-robin
// merge onto one stream, pixel counters and frame-done flag.
module ray_result_collector
  import ray_result_collector_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int DATA_W     = RC_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = RC_CNT_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  ray_result_collector_if.slave      bus,
  input  logic                       reset_pixel_counter,
  input  logic [CNT_W-1:0]           frame_pixels,
  output logic [NUM_CORES-1:0]       overflow,
  output logic [CNT_W-1:0]           pixel_counter,
  output logic [NUM_CORES*CNT_W-1:0] core_pixel_counter,
  output logic                       frame_done
);

  localparam int CORE_W = rc_core_w(NUM_CORES);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  logic [FCW-1:0]       cnt  [NUM_CORES];
  logic [DATA_W-1:0]    dout [NUM_CORES];
  logic [CNT_W-1:0]     core_cnt [NUM_CORES];
  logic [NUM_CORES-1:0] push;
  logic [NUM_CORES-1:0] pop;
  logic [NUM_CORES-1:0] drop;
  logic [NUM_CORES-1:0] busy;
  logic [NUM_CORES-1:0] full;

  logic [CORE_W-1:0] rr_ptr;
  logic [CORE_W-1:0] gnt_idx;
  logic [CORE_W-1:0] scan;
  logic              gnt_valid;
  logic              load;
  logic              xfer;

  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [CORE_W-1:0] out_core_q;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    assign busy[i] = cnt[i] != '0;
    assign push[i] = bus.in_valid[i] && (cnt[i] != FCW'(FIFO_DEPTH));
    assign drop[i] = bus.in_valid[i] && (cnt[i] == FCW'(FIFO_DEPTH));
    assign full[i] = cnt[i] >= FCW'(FIFO_DEPTH - 1);
    assign pop[i]  = load && gnt_valid && (gnt_idx == CORE_W'(i));
    assign core_pixel_counter[i*CNT_W +: CNT_W] = core_cnt[i];

    result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
    ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push[i]),
      .pop    (pop[i]),
      .din    (bus.in_data[i*DATA_W +: DATA_W]),
      .dout   (dout[i]),
      .count  (cnt[i])
    );
  end

  assign load          = !out_valid_q || bus.out_ready;
  assign xfer          = out_valid_q && bus.out_ready;
  assign bus.fifo_full = full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_core  = out_core_q;

  // search starts just past the last grant, wrapping
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      scan = CORE_W'((int'(rr_ptr) + k) % NUM_CORES);
      if (!gnt_valid && busy[scan]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_core_q  <= '0;
      rr_ptr      <= CORE_W'(NUM_CORES - 1);
    end else if (load) begin
      out_valid_q <= gnt_valid;
      if (gnt_valid) begin
        out_data_q <= dout[gnt_idx];
        out_core_q <= gnt_idx;
        rr_ptr     <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_counter <= '0;
      frame_done    <= 1'b0;
      overflow      <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_cnt[i] <= '0;
    end else if (reset_pixel_counter) begin
      pixel_counter <= '0;
      frame_done    <= 1'b0;
      overflow      <= '0;
      for (int i = 0; i < NUM_CORES; i++) core_cnt[i] <= '0;
    end else begin
      overflow <= overflow | drop;
      if (xfer) begin
        pixel_counter <= pixel_counter + CNT_W'(1);
        core_cnt[out_core_q] <= core_cnt[out_core_q] + CNT_W'(1);
        if ((frame_pixels != '0) &&
            (pixel_counter + CNT_W'(1) == frame_pixels))
          frame_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ray_result_collector.sv
// Randomised bench for ray_result_collector against a queue-based
// reference model of the collector's transfer rules.
module tb_ray_result_collector;
  import ray_result_collector_pkg::*;

  localparam int NC    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic           rpc;
  logic [CW-1:0]  fp;
  logic [NC-1:0]  overflow;
  logic [CW-1:0]  pc;
  logic [NC*CW-1:0] cpc;
  logic           fd;

  int checks = 0;
  int errors = 0;

  ray_result_collector_if #(.NUM_CORES(NC), .DATA_W(DW)) bus();

  ray_result_collector #(
    .NUM_CORES  (NC),
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CW)
  ) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .bus                 (bus),
    .reset_pixel_counter (rpc),
    .frame_pixels        (fp),
    .overflow            (overflow),
    .pixel_counter       (pc),
    .core_pixel_counter  (cpc),
    .frame_done          (fd)
  );

  always #5 clk = ~clk;

  // reference model
  pixel_result_t mq [NC][$];
  logic          m_ov;
  pixel_result_t m_data;
  logic [1:0]    m_core;
  int            m_ptr;
  logic [CW-1:0] m_pc;
  logic [CW-1:0] m_cc [NC];
  logic          m_fd;
  logic [NC-1:0] m_ovf;

  task automatic m_reset();
    for (int i = 0; i < NC; i++) begin
      mq[i].delete();
      m_cc[i] = '0;
    end
    m_ov = 0; m_data = '0; m_core = '0; m_ptr = NC - 1;
    m_pc = '0; m_fd = 0; m_ovf = '0;
  endtask

  task automatic m_tick();
    int sz [NC];
    int g;
    int j;
    for (int i = 0; i < NC; i++) sz[i] = mq[i].size();
    if (m_ov && bus.out_ready) begin
      m_pc = m_pc + 1;
      m_cc[m_core] = m_cc[m_core] + 1;
      if (fp != 0 && m_pc == fp) m_fd = 1;
    end
    if (!m_ov || bus.out_ready) begin
      g = -1;
      for (int k = 1; k <= NC; k++) begin
        j = (m_ptr + k) % NC;
        if (g < 0 && sz[j] > 0) g = j;
      end
      if (g >= 0) begin
        m_data = mq[g].pop_front();
        m_core = 2'(g);
        m_ptr  = g;
        m_ov   = 1;
      end else begin
        m_ov = 0;
      end
    end
    for (int i = 0; i < NC; i++)
      if (bus.in_valid[i]) begin
        if (sz[i] < DEPTH) mq[i].push_back(bus.in_data[i*DW +: DW]);
        else m_ovf[i] = 1;
      end
    if (rpc) begin
      m_pc = '0; m_fd = 0; m_ovf = '0;
      for (int i = 0; i < NC; i++) m_cc[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_tick();
    @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid = '0;
    bus.out_ready = 1'b1;
    rpc = 1'b0;
    repeat (NC * DEPTH + 4) step();
  endtask

  task automatic test_reset();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0 || bus.out_core !== '0) begin
      errors++;
      $display("FAIL reset_out got=%h/%0d exp=0/0", bus.out_data, bus.out_core);
    end
    checks++;
    if (pc !== '0 || cpc !== '0) begin
      errors++; $display("FAIL reset_counters got=%0d/%h exp=0", pc, cpc);
    end
    checks++;
    if (fd !== 1'b0 || overflow !== '0 || bus.fifo_full !== '0) begin
      errors++;
      $display("FAIL reset_flags got fd=%b ovf=%b full=%b exp=0",
               fd, overflow, bus.fifo_full);
    end
  endtask

  task automatic test_all_cores();
    pixel_result_t w [NC];
    bus.out_ready = 1'b1;
    for (int c = 0; c < NC; c++) begin
      w[c] = {$urandom, $urandom};
      bus.in_data[c*DW +: DW] = w[c];
    end
    bus.in_valid = '1;
    step();
    bus.in_valid = '0;
    for (int c = 0; c < NC; c++) begin
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_core !== 2'(c)) begin
        errors++;
        $display("FAIL all_cores_order got v=%b core=%0d exp v=1 core=%0d",
                 bus.out_valid, bus.out_core, c);
      end
      checks++;
      if (bus.out_data !== w[c]) begin
        errors++;
        $display("FAIL all_cores_data got=%h exp=%h", bus.out_data, w[c]);
      end
    end
    step();
    checks++;
    if (pc !== 32'd4) begin
      errors++; $display("FAIL all_cores_pc got=%0d exp=4", pc);
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (cpc[c*CW +: CW] !== 32'd1) begin
        errors++;
        $display("FAIL all_cores_cc%0d got=%0d exp=1", c, cpc[c*CW +: CW]);
      end
    end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    bus.in_data[DW-1:0] = 64'hA5;
    bus.in_valid = 4'b0001;
    step();
    bus.in_valid = '0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL single_latency got=%b exp=0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 64'hA5 ||
        bus.out_core !== 2'd0) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h c=%0d exp v=1 d=a5 c=0",
               bus.out_valid, bus.out_data, bus.out_core);
    end
    step();
    checks++;
    if (pc !== m_pc || cpc[CW-1:0] !== m_cc[0]) begin
      errors++;
      $display("FAIL single_count got=%0d/%0d exp=%0d/%0d",
               pc, cpc[CW-1:0], m_pc, m_cc[0]);
    end
  endtask

  task automatic test_backpressure();
    int seen;
    bus.out_ready = 1'b0;
    bus.in_valid = 4'b0100;
    for (int n = 0; n < DEPTH + 2; n++) begin
      bus.in_data[2*DW +: DW] = {$urandom, $urandom};
      step();
      checks++;
      if (bus.fifo_full[2] !== (mq[2].size() >= DEPTH - 1) ||
          overflow[2] !== m_ovf[2]) begin
        errors++;
        $display("FAIL bp_flags got full=%b ovf=%b exp full=%b ovf=%b",
                 bus.fifo_full[2], overflow[2],
                 mq[2].size() >= DEPTH - 1, m_ovf[2]);
      end
    end
    bus.in_valid = '0;
    checks++;
    if (overflow[2] !== 1'b1) begin
      errors++; $display("FAIL bp_overflow got=%b exp=1", overflow[2]);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== m_data) begin
      errors++;
      $display("FAIL bp_hold got v=%b d=%h exp v=1 d=%h",
               bus.out_valid, bus.out_data, m_data);
    end
    bus.out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < DEPTH + 4; n++) begin
      if (bus.out_valid) seen++;
      step();
      checks++;
      if (bus.out_valid !== m_ov ||
          (m_ov && (bus.out_data !== m_data || bus.out_core !== 2'd2))) begin
        errors++;
        $display("FAIL bp_stream got v=%b d=%h exp v=%b d=%h",
                 bus.out_valid, bus.out_data, m_ov, m_data);
      end
    end
    checks++;
    if (seen != DEPTH + 1) begin
      errors++; $display("FAIL bp_delivered got=%0d exp=%0d", seen, DEPTH + 1);
    end
    rpc = 1'b1;
    step();
    rpc = 1'b0;
    checks++;
    if (overflow !== '0) begin
      errors++; $display("FAIL bp_ovf_clear got=%b exp=0", overflow);
    end
  endtask

  task automatic test_frame_done();
    int pushed;
    fp = 32'd3;
    bus.out_ready = 1'b1;
    pushed = 0;
    for (int n = 0; n < 14; n++) begin
      bus.in_valid = (pushed < 5) ? 4'b0010 : 4'b0000;
      bus.in_data[DW +: DW] = {$urandom, $urandom};
      if (pushed < 5) pushed++;
      rpc = (m_ov && m_pc == 4) ? 1'b1 : 1'b0;
      step();
      checks++;
      if (fd !== m_fd || pc !== m_pc) begin
        errors++;
        $display("FAIL frame_track got fd=%b pc=%0d exp fd=%b pc=%0d",
                 fd, pc, m_fd, m_pc);
      end
      if (m_pc == 3 || m_pc == 4) begin
        checks++;
        if (fd !== 1'b1) begin
          errors++; $display("FAIL frame_done_set got=%b exp=1", fd);
        end
      end
    end
    rpc = 1'b0;
    checks++;
    if (pc !== '0 || fd !== 1'b0) begin
      errors++;
      $display("FAIL frame_clear got pc=%0d fd=%b exp 0/0", pc, fd);
    end
    fp = '0;
  endtask

  task automatic test_fairness();
    int prev;
    int n;
    rpc = 1'b1;
    step();
    rpc = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b1001;
    prev = -1;
    n = 0;
    while (m_pc != 100 && n < 400) begin
      bus.in_data[0 +: DW]    = {$urandom, $urandom};
      bus.in_data[3*DW +: DW] = {$urandom, $urandom};
      step();
      n++;
      checks++;
      if (bus.out_valid !== m_ov ||
          (m_ov && (bus.out_core !== m_core || bus.out_data !== m_data))) begin
        errors++;
        $display("FAIL fair_out got v=%b c=%0d exp v=%b c=%0d",
                 bus.out_valid, bus.out_core, m_ov, m_core);
      end
      if (m_ov) begin
        if (prev >= 0) begin
          checks++;
          if (int'(bus.out_core) == prev) begin
            errors++;
            $display("FAIL fair_alternate got=%0d exp!=%0d", bus.out_core, prev);
          end
        end
        prev = int'(bus.out_core);
      end
    end
    bus.in_valid = '0;
    checks++;
    if (n >= 400) begin
      errors++; $display("FAIL fair_timeout got=%0d exp=100", m_pc);
    end
    checks++;
    if (cpc[0 +: CW] !== 32'd50 || cpc[3*CW +: CW] !== 32'd50) begin
      errors++;
      $display("FAIL fair_counts got=%0d/%0d exp=50/50",
               cpc[0 +: CW], cpc[3*CW +: CW]);
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] ef;
    fp = CW'($urandom_range(10, 60));
    for (int n = 0; n < 400; n++) begin
      bus.in_valid  = NC'($urandom);
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 9) < 7);
      rpc           = ($urandom_range(0, 99) < 2);
      step();
      for (int i = 0; i < NC; i++) ef[i] = mq[i].size() >= DEPTH - 1;
      checks++;
      if (bus.out_valid !== m_ov) begin
        errors++; $display("FAIL rnd_valid got=%b exp=%b", bus.out_valid, m_ov);
      end
      if (m_ov) begin
        checks++;
        if (bus.out_data !== m_data || bus.out_core !== m_core) begin
          errors++;
          $display("FAIL rnd_data got=%h/%0d exp=%h/%0d",
                   bus.out_data, bus.out_core, m_data, m_core);
        end
      end
      checks++;
      if (bus.fifo_full !== ef || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rnd_flags got full=%b ovf=%b exp full=%b ovf=%b",
                 bus.fifo_full, overflow, ef, m_ovf);
      end
      checks++;
      if (pc !== m_pc || fd !== m_fd) begin
        errors++;
        $display("FAIL rnd_pc got=%0d/%b exp=%0d/%b", pc, fd, m_pc, m_fd);
      end
      for (int i = 0; i < NC; i++) begin
        checks++;
        if (cpc[i*CW +: CW] !== m_cc[i]) begin
          errors++;
          $display("FAIL rnd_cc%0d got=%0d exp=%0d",
                   i, cpc[i*CW +: CW], m_cc[i]);
        end
      end
    end
    rpc = 1'b0;
    fp = '0;
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0110;
    step();
    bus.out_ready = 1'b0;
    repeat (3) step();
    bus.in_valid = '0;
    #2;
    resetn = 1'b0;
    #1;
    m_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
        bus.out_core !== '0) begin
      errors++;
      $display("FAIL areset_out got v=%b d=%h c=%0d exp 0",
               bus.out_valid, bus.out_data, bus.out_core);
    end
    checks++;
    if (pc !== '0 || cpc !== '0 || fd !== 1'b0 ||
        overflow !== '0 || bus.fifo_full !== '0) begin
      errors++;
      $display("FAIL areset_state got pc=%0d fd=%b ovf=%b full=%b exp 0",
               pc, fd, overflow, bus.fifo_full);
    end
    @(negedge clk);
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 4'b1001;
    step();
    bus.in_valid = '0;
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_core !== 2'd0 ||
        bus.out_data !== m_data) begin
      errors++;
      $display("FAIL areset_first got v=%b c=%0d exp v=1 c=0",
               bus.out_valid, bus.out_core);
    end
    step();
    checks++;
    if (bus.out_core !== 2'd3) begin
      errors++; $display("FAIL areset_second got=%0d exp=3", bus.out_core);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    rpc = 1'b0;
    fp = '0;
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    test_reset();
    test_all_cores();
    test_single();
    drain();
    test_backpressure();
    drain();
    test_frame_done();
    drain();
    test_fairness();
    drain();
    test_random();
    drain();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
